// File: rtl/svc_rv_io_uart_pkg.sv
// Shared constants and types for the io-bus UART transmitter.
package svc_rv_io_uart_pkg;

  // Register offsets, as decoded from addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/svc_uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART serializer.
module svc_uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Pushes while full and pops while empty are dropped here
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2)
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/svc_rv_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the io_* bus: register decode plus serializer.
module svc_rv_io_uart_tx
  import svc_rv_io_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        txd,
  output logic        tx_busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       wr_sel;
  logic             push_req, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      wmask;
  logic             ovf_q, ovf_d;
  logic [DIV_W-1:0] div_q, div_d;
  uart_tx_state_t   state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             unused_bits;

  assign wr_sel   = io_waddr[3:2];
  assign push_req = io_wen && (wr_sel == REG_TXDATA) && io_wstrb[0];
  assign wmask    = {{8{io_wstrb[3]}}, {8{io_wstrb[2]}}, {8{io_wstrb[1]}}, {8{io_wstrb[0]}}};
  assign unused_bits = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4], io_waddr[1:0],
                         io_wdata, wmask};

  svc_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_req),
    .wdata_i (io_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Control register writes; an overflowing push beats a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    div_d = div_q;
    if (io_wen && (wr_sel == REG_STATUS) && io_wstrb[0] && io_wdata[3]) ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if (io_wen && (wr_sel == REG_DIV)) begin
      div_d = (div_q & ~wmask[DIV_W-1:0]) | (io_wdata[DIV_W-1:0] & wmask[DIV_W-1:0]);
    end
  end

  // Serializer next-state: each bit holds for div+1 cycles, divider sampled at every reload
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = div_q;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - DIV_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the next state so txd comes straight from a flop
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // All control and serializer state; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (state_q != IDLE) || !fifo_empty;

  // Side-effect-free read mux from current state only
  always_comb begin
    io_rdata = '0;
    case (io_raddr[3:2])
      REG_STATUS: begin
        io_rdata[STAT_BUSY]             = tx_busy;
        io_rdata[STAT_FULL]             = fifo_full;
        io_rdata[STAT_EMPTY]            = fifo_empty;
        io_rdata[STAT_OVF]              = ovf_q;
        io_rdata[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
      end
      REG_DIV: io_rdata[DIV_W-1:0] = div_q;
      default: io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_svc_rv_io_uart_tx.sv
// Directed bench for the io-bus UART transmitter with a byte scoreboard on txd.
module tb_svc_rv_io_uart_tx;

  localparam int LOG_N = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        txd, tx_busy;

  int          cyc = 0;
  logic        txd_log  [LOG_N];
  logic        busy_log [LOG_N];
  logic [7:0]  sb [$];
  int          n_checks = 0;
  int          n_fail = 0;

  svc_rv_io_uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .io_wen   (io_wen),
    .io_waddr (io_waddr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .txd      (txd),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      txd_log[cyc]  = txd;
      busy_log[cyc] = tx_busy;
    end
  end

  function automatic int ix(input int i);
    return (i < LOG_N) ? i : LOG_N - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    io_wen   = 1'b1;
    io_waddr = {28'h0, a};
    io_wdata = d;
    io_wstrb = s;
    @(posedge clk);
    #1;
    io_wen   = 1'b0;
    io_wstrb = '0;
  endtask

  task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    io_raddr = {28'h0, a};
    #1;
    check(tag, io_rdata, exp);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && tx_busy !== 1'b0; i++) step(1);
    check(tag, tx_busy, 1'b0);
    step(2);
  endtask

  // Exact per-cycle frame check; slots before sw last l0 cycles, the rest l1
  task automatic check_wave(input string tag, input int t0, input logic [7:0] b,
                            input int l0, input int l1, input int sw);
    int t;
    t = t0;
    for (int s = 0; s < 10; s++) begin
      int   len;
      logic e;
      len = (s < sw) ? l0 : l1;
      if (s == 0)      e = 1'b0;
      else if (s == 9) e = 1'b1;
      else             e = b[s-1];
      for (int k = 0; k < len; k++) begin
        check(tag, txd_log[ix(t)], e);
        t++;
      end
    end
  endtask

  // Finds the next start bit at or after 'from', decodes it, compares with the scoreboard
  task automatic decode_next(input string tag, input int from, input int ls, input int l,
                             output int nxt);
    int         s;
    logic [7:0] got, exp;
    s = from;
    while (s < cyc && txd_log[ix(s)] !== 1'b0) s++;
    check({tag, "_found"}, (s < cyc) ? 1 : 0, 1);
    for (int i = 0; i < 8; i++) got[i] = txd_log[ix(s + ls + i * l + l / 2)];
    check({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
    exp = 8'h00;
    if (sb.size() > 0) exp = sb.pop_front();
    check({tag, "_byte"}, got, exp);
    check({tag, "_stop"}, txd_log[ix(s + ls + 8 * l + l / 2)], 1'b1);
    nxt = s + ls + 9 * l;
  endtask

  initial begin
    int n, m, p, r, z;

    // Reset state and register access
    step(3);
    rst = 1'b0;
    rdchk("rst_status", 4'h4, 32'h0000_0004);
    rdchk("rst_div", 4'h8, 32'd867);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    rdchk("txdata_reads_0", 4'h0, 32'h0);
    rdchk("reserved_reads_0", 4'hC, 32'h0);
    wr(4'h8, 32'h0000_1234, 4'b0001);
    rdchk("div_byte_strobe", 4'h8, 32'h0000_0334);
    wr(4'h8, 32'hFFFF_FFFF, 4'b1111);
    rdchk("div_upper_zero", 4'h8, 32'h0000_FFFF);
    wr(4'hC, 32'h1234_5678, 4'b1111);
    wr(4'h4, 32'hFFFF_FFF7, 4'b1111);
    rdchk("reserved_wr_ignored", 4'h8, 32'h0000_FFFF);
    rdchk("status_wr_ignored", 4'h4, 32'h0000_0004);

    // Single frame, div=3
    wr(4'h8, 32'd3, 4'b0011);
    n = cyc;
    sb.push_back(8'h55);
    wr(4'h0, 32'h0000_0055, 4'b0001);
    rdchk("t2_status_n1", 4'h4, 32'h0000_0101);
    wait_cyc(n + 45);
    check("t2_idle_n1", txd_log[n + 1], 1'b1);
    check_wave("t2_wave", n + 2, 8'h55, 4, 4, 10);
    check("t2_busy_stop", busy_log[n + 41], 1'b1);
    check("t2_busy_fall", busy_log[n + 42], 1'b0);
    decode_next("t2", n, 4, 4, p);

    // Fill to full behind a long start bit, overflow, clear, then drain at div=0
    wr(4'h8, 32'd60, 4'b0011);
    m = cyc;
    sb.push_back(8'hEE);
    wr(4'h0, 32'h0000_00EE, 4'b0001);
    step(5);
    n = cyc;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(8'(i));
      wr(4'h0, 32'(i), 4'b0001);
    end
    rdchk("t3_full", 4'h4, 32'h0000_1003);
    wr(4'h0, 32'h0000_0010, 4'b0001);
    rdchk("t3_overflow", 4'h4, 32'h0000_100B);
    wr(4'h4, 32'h0000_0008, 4'b0001);
    rdchk("t3_ovf_cleared", 4'h4, 32'h0000_1003);
    wr(4'h8, 32'd0, 4'b0011);
    wait_idle("t3_drain");
    decode_next("t3_ee", m, 61, 1, p);
    for (int i = 0; i < 16; i++) decode_next("t3_fifo", p, 1, 1, p);
    z = 0;
    for (int i = p; i < cyc; i++) if (txd_log[ix(i)] === 1'b0) z++;
    check("t3_no_extra_frame", z, 0);
    rdchk("t3_status_end", 4'h4, 32'h0000_0004);

    // Back-to-back frames, div=1
    wr(4'h8, 32'd1, 4'b0011);
    n = cyc;
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    wr(4'h0, 32'h0000_00A5, 4'b0001);
    wr(4'h0, 32'h0000_003C, 4'b0001);
    wait_idle("t4_drain");
    check("t4_start1", txd_log[n + 2], 1'b0);
    check("t4_stop1", txd_log[n + 21], 1'b1);
    check("t4_gap", txd_log[n + 22], 1'b1);
    check("t4_start2", txd_log[n + 23], 1'b0);
    decode_next("t4_a", n, 2, 2, p);
    decode_next("t4_b", p, 2, 2, p);
    check("t4_next_start", p - 20, n + 23);

    // Divider change during data bit 3
    wr(4'h8, 32'd7, 4'b0011);
    n = cyc;
    wr(4'h0, 32'h0000_006B, 4'b0001);
    wait_cyc(n + 36);
    wr(4'h8, 32'd1, 4'b0011);
    wait_idle("t5_drain");
    check_wave("t5_wave", n + 2, 8'h6B, 8, 2, 5);
    check("t5_busy_stop", busy_log[n + 51], 1'b1);
    check("t5_busy_fall", busy_log[n + 52], 1'b0);

    // Reset mid-frame with bytes queued
    wr(4'h8, 32'd3, 4'b0011);
    n = cyc;
    wr(4'h0, 32'h0000_00C1, 4'b0001);
    wr(4'h0, 32'h0000_00C2, 4'b0001);
    wr(4'h0, 32'h0000_00C3, 4'b0001);
    wr(4'h0, 32'h0000_00C4, 4'b0001);
    wait_cyc(n + 12);
    rst = 1'b1;
    r = cyc;
    step(1);
    rst = 1'b0;
    check("t6_txd_after_rst", txd, 1'b1);
    rdchk("t6_status", 4'h4, 32'h0000_0004);
    rdchk("t6_div", 4'h8, 32'd867);
    check("t6_busy", tx_busy, 1'b0);
    step(200);
    check("t6_pre_rst_low", txd_log[r], 1'b0);
    z = 0;
    for (int i = r + 1; i < cyc; i++) if (txd_log[ix(i)] === 1'b0) z++;
    check("t6_no_tx", z, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
